cam_stream_tx: RTL and testbench
================================

Name: cam_stream_tx

Overview:
- Camera-sensor-side transmitter for the parallel video port (PIXEL_DATA / LINE_VALID / FRAME_VALID).
- Accepts pixels on a ready/valid stream, buffers them in an internal FIFO, and replays them with sensor-style frame/line timing and blanking.
- Used as an on-chip camera emulator, so the video capture path can be exercised without the physical sensor.

Parameters:
- DATA_W, 10, pixel width; matches the video port pixel bus.
- ACTIVE_W, 640, pixels per line (LINE_VALID high cycles).
- ACTIVE_H, 480, lines per frame.
- HBLANK, 16, LINE_VALID-low cycles between lines; minimum 1.
- FV_LEAD, 4, cycles FRAME_VALID is high before the first LINE_VALID; minimum 1.
- FV_TRAIL, 4, cycles FRAME_VALID stays high after the last line's LINE_VALID falls; minimum 1.
- VBLANK, 32, FRAME_VALID-low cycles after each frame; minimum 1.
- FIFO_DEPTH, 16, input buffer depth in words; power of 2.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  permits a new frame to start.
- src_data  in  DATA_W  input pixel.
- src_sop  in  1  marks the first pixel of a frame.
- src_valid  in  1  src_data/src_sop valid.
- src_ready  out  1  FIFO not full.
- pixel_data  out  DATA_W  registered pixel; 0 whenever line_valid=0.
- line_valid  out  1  registered.
- frame_valid  out  1  registered.
- underflow  out  1  sticky; FIFO was empty during an active pixel.
- frame_count  out  16  completed frames, wraps at 0xFFFF->0.

Behaviour:
- Reset values: all outputs 0, FIFO flushed, FSM in IDLE, counters 0. Reset asserted mid-frame drops line_valid and frame_valid on the next edge. There is no partial-frame completion.
- FIFO write: occurs when src_valid && src_ready; stores {sop, data}. src_ready is combinational !full.
- FIFO read: occurs only in ACTIVE, or when discarding in SYNC.
- FSM states:
  - IDLE: when enable=1 and FIFO is non-empty, go to SYNC.
  - SYNC: if the FIFO head has sop=1, go to LEAD with the FV_LEAD counter loaded. Otherwise pop and discard the head (one word per cycle). If the FIFO is empty, wait in SYNC.
  - LEAD: frame_valid=1 for FV_LEAD cycles, then go to ACTIVE with col=0, row=0.
  - ACTIVE: line_valid=1 and frame_valid=1. Pop one word per cycle and drive its data onto pixel_data.
    - After col=ACTIVE_W-1: if row=ACTIVE_H-1, go to TRAIL; else go to HBL.
  - HBL: line_valid=0 and frame_valid=1 for HBLANK cycles; row++; return to ACTIVE.
  - TRAIL: frame_valid=1 for FV_TRAIL cycles. On exit, frame_count++, then go to VBL.
  - VBL: frame_valid=0 for VBLANK cycles, then go to IDLE.
- Outputs are registered: the state decision in cycle N is visible on the pins at N+1. Latency from a sop word at the FIFO head in SYNC to the first line_valid=1 is FV_LEAD+1 cycles.
- Underflow in ACTIVE: timing continues, pixel_data=0, underflow is set, and no pop occurs. underflow clears only on reset.
- A sop=1 word popped in ACTIVE at a position other than col=0/row=0 is transmitted as an ordinary pixel; no resync occurs mid-frame.
- enable deasserted mid-frame: the current frame completes normally; the FSM then holds in IDLE.
- Simultaneous push and pop with the FIFO full: the pop frees a slot, but src_ready stays 0 that cycle because it depends on the registered full flag.
- Counters are sized with $clog2; arithmetic is unsigned and wrapping.

Optional Feature:
- CAM_TX_TEST_PATTERN_EN defined:
  - Adds input pattern_en (1 bit).
  - When pattern_en=1 is sampled in IDLE, the frame is generated internally: SYNC is skipped, no FIFO pops occur, and pixel_data = (col + row) truncated to DATA_W (diagonal ramp). underflow is not affected.
  - pattern_en is held for the whole frame once sampled.
  - Frame start with pattern_en=1 requires only enable=1; the FIFO may be empty.
- Undefined: no pattern_en port; behaviour is as above.

Test Plan (ACTIVE_W=4, ACTIVE_H=2, HBLANK=2, FV_LEAD=3, FV_TRAIL=3, VBLANK=5, FIFO_DEPTH=16):
- Basic frame: push 8 words 0x001..0x008 (sop on first), then enable=1 -> frame_valid high for 3 cycles, then line_valid high 4 cycles with 1,2,3,4; low 2 cycles; high with 5,6,7,8; frame_valid falls 3 cycles later; frame_count=1.
- Resync: push 0x3FF, 0x3FE (no sop), then 8 words with sop on 0x010 -> 0x3FF and 0x3FE are discarded; the first pixel out is 0x010.
- Underflow: push only 5 words with sop, enable=1 -> pixels 1..5, then 0,0,0 with line_valid still high; underflow=1; timing is unchanged.
- Backpressure: push 20 words with no pops (enable=0) -> src_ready=0 after the 16th accept; exactly 16 words are stored.
- Reset mid-frame: assert reset during row 1, col 2 -> line_valid, frame_valid, pixel_data and underflow are 0 on the next edge; frame_count=0; src_ready=1.
- Enable drop: deassert enable during row 0 -> the frame completes, frame_count increments, and no second frame starts although the FIFO holds a sop word.

Source files
------------

// File: rtl/cam_stream_tx.sv
// Camera-sensor emulator: buffers a pixel stream in a FIFO and replays it with
// FRAME_VALID/LINE_VALID timing. Optional macro CAM_TX_TEST_PATTERN_EN adds an internal diagonal ramp.
module cam_stream_tx #(
    parameter int DATA_W     = 10,
    parameter int ACTIVE_W   = 640,
    parameter int ACTIVE_H   = 480,
    parameter int HBLANK     = 16,
    parameter int FV_LEAD    = 4,
    parameter int FV_TRAIL   = 4,
    parameter int VBLANK     = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
`ifdef CAM_TX_TEST_PATTERN_EN
    input  logic              pattern_en,
`endif
    input  logic [DATA_W-1:0] src_data,
    input  logic              src_sop,
    input  logic              src_valid,
    output logic              src_ready,
    output logic [DATA_W-1:0] pixel_data,
    output logic              line_valid,
    output logic              frame_valid,
    output logic              underflow,
    output logic [15:0]       frame_count
);

    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int COL_W  = (ACTIVE_W > 1) ? $clog2(ACTIVE_W) : 1;
    localparam int ROW_W  = (ACTIVE_H > 1) ? $clog2(ACTIVE_H) : 1;
    localparam int MAX_A  = (HBLANK > FV_LEAD) ? HBLANK : FV_LEAD;
    localparam int MAX_B  = (FV_TRAIL > VBLANK) ? FV_TRAIL : VBLANK;
    localparam int MAX_BL = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W  = $clog2(MAX_BL + 1);

    localparam logic [AW:0]       FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW-1:0]     PTR_ONE  = AW'(1);
    localparam logic [AW:0]       CNT_ONE1 = (AW+1)'(1);
    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(ACTIVE_W - 1);
    localparam logic [COL_W-1:0]  COL_ONE  = COL_W'(1);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(ACTIVE_H - 1);
    localparam logic [ROW_W-1:0]  ROW_ONE  = ROW_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  LEAD_LD  = CNT_W'(FV_LEAD - 1);
    localparam logic [CNT_W-1:0]  HBL_LD   = CNT_W'(HBLANK - 1);
    localparam logic [CNT_W-1:0]  TRAIL_LD = CNT_W'(FV_TRAIL - 1);
    localparam logic [CNT_W-1:0]  VBL_LD   = CNT_W'(VBLANK - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SYNC, S_LEAD, S_ACTIVE, S_HBL, S_TRAIL, S_VBL
    } state_t;

    logic [DATA_W:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
    logic [AW:0]       r_count;
    state_t            r_state, w_next;
    logic [CNT_W-1:0]  r_cnt, w_cnt_n;
    logic [COL_W-1:0]  r_col, w_col_n;
    logic [ROW_W-1:0]  r_row, w_row_n;
    logic [DATA_W-1:0] r_pixel, w_pix_n;
    logic              r_lv, r_fv, r_underflow;
    logic [15:0]       r_frame_count;

    logic              w_full, w_empty, w_push, w_pop_fifo;
    logic              w_discard, w_want_px, w_pop_px, w_frame_done;
    logic [DATA_W:0]   w_head;
    logic              w_pat, w_start_pat;

    assign w_full     = (r_count == FULL_CNT);
    assign w_empty    = (r_count == '0);
    assign w_push     = src_valid && !w_full;
    assign w_pop_fifo = w_pop_px || w_discard;
    assign w_head     = r_mem[r_rd_ptr];

`ifdef CAM_TX_TEST_PATTERN_EN
    logic r_pat;
    assign w_pat       = r_pat;
    assign w_start_pat = pattern_en;

    always_ff @(posedge clk) begin
        if (reset)
            r_pat <= 1'b0;
        else if (r_state == S_IDLE)
            r_pat <= pattern_en;
    end
`else
    assign w_pat       = 1'b0;
    assign w_start_pat = 1'b0;
`endif

    // NOTE: the storage array is not reset; flushing only needs the pointers and count cleared.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= {src_sop, src_data};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)     r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop_fifo) r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_push, w_pop_fifo})
                2'b10:   r_count <= r_count + CNT_ONE1;
                2'b01:   r_count <= r_count - CNT_ONE1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Outputs are registered from the next-state decision, so a pixel is popped
    // one cycle before it appears on the pins together with line_valid.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        w_next       = r_state;
        w_cnt_n      = r_cnt;
        w_col_n      = r_col;
        w_row_n      = r_row;
        w_discard    = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable && w_start_pat) begin
                    w_next  = S_LEAD;
                    w_cnt_n = LEAD_LD;
                end else if (enable && !w_empty) begin
                    w_next = S_SYNC;
                end
            end
            S_SYNC: begin
                if (!w_empty) begin
                    if (w_head[DATA_W]) begin
                        w_next  = S_LEAD;
                        w_cnt_n = LEAD_LD;
                    end else begin
                        w_discard = 1'b1;
                    end
                end
            end
            S_LEAD: begin
                if (r_cnt == '0) begin
                    w_next  = S_ACTIVE;
                    w_col_n = '0;
                    w_row_n = '0;
                end else begin
                    w_cnt_n = r_cnt - CNT_ONE;
                end
            end
            S_ACTIVE: begin
                if (r_col == COL_LAST) begin
                    if (r_row == ROW_LAST) begin
                        w_next  = S_TRAIL;
                        w_cnt_n = TRAIL_LD;
                    end else begin
                        w_next  = S_HBL;
                        w_cnt_n = HBL_LD;
                        w_row_n = r_row + ROW_ONE;
                    end
                end else begin
                    w_col_n = r_col + COL_ONE;
                end
            end
            S_HBL: begin
                if (r_cnt == '0) begin
                    w_next  = S_ACTIVE;
                    w_col_n = '0;
                end else begin
                    w_cnt_n = r_cnt - CNT_ONE;
                end
            end
            S_TRAIL: begin
                if (r_cnt == '0) begin
                    w_next       = S_VBL;
                    w_cnt_n      = VBL_LD;
                    w_frame_done = 1'b1;
                end else begin
                    w_cnt_n = r_cnt - CNT_ONE;
                end
            end
            S_VBL: begin
                if (r_cnt == '0)
                    w_next = S_IDLE;
                else
                    w_cnt_n = r_cnt - CNT_ONE;
            end
            default: w_next = S_IDLE;
        endcase

        w_want_px = (w_next == S_ACTIVE) && !w_pat;
        w_pop_px  = w_want_px && !w_empty;

        w_pix_n = '0;
        if (w_next == S_ACTIVE) begin
            if (w_pat)
                w_pix_n = DATA_W'(w_col_n) + DATA_W'(w_row_n);
            else if (!w_empty)
                w_pix_n = w_head[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_col         <= '0;
            r_row         <= '0;
            r_pixel       <= '0;
            r_lv          <= 1'b0;
            r_fv          <= 1'b0;
            r_underflow   <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_n;
            r_col   <= w_col_n;
            r_row   <= w_row_n;
            r_pixel <= w_pix_n;
            r_lv    <= (w_next == S_ACTIVE);
            r_fv    <= (w_next == S_LEAD) || (w_next == S_ACTIVE) ||
                       (w_next == S_HBL)  || (w_next == S_TRAIL);
            if (w_want_px && w_empty)
                r_underflow <= 1'b1;
            if (w_frame_done)
                r_frame_count <= r_frame_count + 16'd1;
        end
    end

    assign src_ready   = !w_full;
    assign pixel_data  = r_pixel;
    assign line_valid  = r_lv;
    assign frame_valid = r_fv;
    assign underflow   = r_underflow;
    assign frame_count = r_frame_count;

endmodule

// File: tb/tb_cam_stream_tx.sv
// Self-checking bench for cam_stream_tx: directed frames with random pixel data,
// compared against a queue-based model of the sensor timing.
module tb_cam_stream_tx;

    localparam int DATA_W = 10;
    localparam int W      = 4;
    localparam int H      = 2;
    localparam int HB     = 2;
    localparam int LEAD   = 3;
    localparam int TRAIL  = 3;
    localparam int VB     = 5;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic [DATA_W-1:0] src_data;
    logic              src_sop;
    logic              src_valid;
    logic              src_ready;
    logic [DATA_W-1:0] pixel_data;
    logic              line_valid;
    logic              frame_valid;
    logic              underflow;
    logic [15:0]       frame_count;

    cam_stream_tx #(
        .DATA_W(DATA_W), .ACTIVE_W(W), .ACTIVE_H(H), .HBLANK(HB),
        .FV_LEAD(LEAD), .FV_TRAIL(TRAIL), .VBLANK(VB), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .src_data(src_data), .src_sop(src_sop), .src_valid(src_valid),
        .src_ready(src_ready), .pixel_data(pixel_data),
        .line_valid(line_valid), .frame_valid(frame_valid),
        .underflow(underflow), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: words buffered in the FIFO, completed frames, sticky underflow.
    logic [DATA_W:0] model_q[$];
    logic [15:0]     model_frames = '0;
    logic            model_ufl = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input string tag, input logic fv, input logic lv, input logic [DATA_W-1:0] pix);
        check({tag, "_fv"}, frame_valid, fv);
        check({tag, "_lv"}, line_valid, lv);
        check({tag, "_pix"}, pixel_data, pix);
        check({tag, "_ufl"}, underflow, model_ufl);
    endtask

    task automatic push(input logic [DATA_W-1:0] d, input logic s);
        src_data  = d;
        src_sop   = s;
        src_valid = 1'b1;
        check("src_ready", src_ready, model_q.size() < DEPTH);
        if (model_q.size() < DEPTH)
            model_q.push_back({s, d});
        tick();
        src_valid = 1'b0;
    endtask

    task automatic idle_quiet(input int n);
        repeat (n) begin
            check("idle_fv", frame_valid, 1'b0);
            check("idle_lv", line_valid, 1'b0);
            tick();
        end
    endtask

    // Returns the number of edges from enable to the first frame_valid cycle.
    task automatic start_frame(output int lat, output int discards);
        discards = 0;
        while (model_q.size() > 0 && model_q[0][DATA_W] == 1'b0) begin
            void'(model_q.pop_front());
            discards++;
        end
        enable = 1'b1;
        lat = 0;
        while (frame_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        check("fv_latency", lat, discards + 2);
        enable = 1'b0;
    endtask

    task automatic run_frame();
        int lat, d;
        logic [DATA_W:0] w;
        start_frame(lat, d);
        repeat (LEAD) begin sample("lead", 1'b1, 1'b0, '0); tick(); end
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                logic [DATA_W-1:0] p;
                if (model_q.size() == 0) begin
                    model_ufl = 1'b1;
                    p = '0;
                end else begin
                    w = model_q.pop_front();
                    p = w[DATA_W-1:0];
                end
                sample("active", 1'b1, 1'b1, p);
                tick();
            end
            if (r < H - 1)
                repeat (HB) begin sample("hblank", 1'b1, 1'b0, '0); tick(); end
        end
        repeat (TRAIL) begin sample("trail", 1'b1, 1'b0, '0); tick(); end
        model_frames++;
        repeat (VB) begin
            sample("vblank", 1'b0, 1'b0, '0);
            check("frame_count", frame_count, model_frames);
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] words [8];
        int lat, d;

        reset = 1'b1; enable = 1'b0;
        src_data = '0; src_sop = 1'b0; src_valid = 1'b0;
        tick(); tick();
        reset = 1'b0;
        sample("reset", 1'b0, 1'b0, '0);
        check("reset_src_ready", src_ready, 1'b1);
        check("reset_frame_count", frame_count, 16'd0);

        // Basic frame with 1..8
        for (int i = 0; i < 8; i++) push(DATA_W'(i + 1), i == 0);
        run_frame();

        // Resync: two non-sop words are discarded; stray sop mid-frame is an ordinary pixel
        push(10'h3FF, 1'b0);
        push(10'h3FE, 1'b0);
        for (int i = 0; i < 8; i++)
            push(DATA_W'($urandom), (i == 0) || ($urandom_range(0, 3) == 0));
        run_frame();

        // Underflow: only 5 words, last 3 pixels are zero and underflow latches
        for (int i = 0; i < 5; i++) push(DATA_W'($urandom), i == 0);
        run_frame();

        // Backpressure: 20 attempts, only 16 accepted; word 8 also carries sop
        for (int i = 0; i < 20; i++) push(DATA_W'($urandom), (i == 0) || (i == 8));
        check("bp_full_ready", src_ready, 1'b0);
        run_frame();
        // Enable was dropped during the frame: no new frame despite a sop at the head
        idle_quiet(20);
        run_frame();
        check("bp_drained_ready", src_ready, 1'b1);
        enable = 1'b1;
        idle_quiet(15);
        enable = 1'b0;

        // Reset mid-frame at row 1, col 2
        for (int i = 0; i < 8; i++) begin
            words[i] = DATA_W'($urandom);
            push(words[i], i == 0);
        end
        start_frame(lat, d);
        repeat (LEAD + W + HB + 2) tick();
        check("mid_lv", line_valid, 1'b1);
        check("mid_pix", pixel_data, words[W + 2]);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_q.delete();
        model_frames = '0;
        model_ufl = 1'b0;
        sample("midreset", 1'b0, 1'b0, '0);
        check("midreset_frame_count", frame_count, 16'd0);
        check("midreset_src_ready", src_ready, 1'b1);
        enable = 1'b1;
        idle_quiet(15);
        enable = 1'b0;

        // Clean frame after reset
        for (int i = 0; i < 8; i++) push(DATA_W'($urandom), i == 0);
        run_frame();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
